i2s_tx_serializer: RTL

- Final output stage of the chorus chain.
- Consumes mixed mono samples and their strobe from the FTS CDC FIFO (slow-clock side) and shifts them out as I2S serial data to the MCU.
- Acts as I2S slave: bit clock is the block clock, word-select comes from the MCU.
- Handles sample hand-off, underrun/overrun, frame-length checking and lock status.

---
 rtl/i2s_tx_serializer_pkg.sv | 19 +
 rtl/i2s_tx_serializer_ws_edge_detect.sv | 24 ++
 rtl/i2s_tx_serializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// Shared types and sizing helpers for the I2S transmit serializer.
package i2s_tx_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LEFT     = 2'd1,
        RIGHT    = 2'd2
    } txState_t;

    localparam int DEF_PKT_WIDTH   = 32'sd16;
    localparam int DEF_SLOT_WIDTH  = 32'sd16;
    localparam int DEF_LOCK_FRAMES = 32'sd2;

    // Bit counter must reach 2*SLOT_WIDTH so a stuck WS line can be recognised.
    function automatic int cntWidth(input int slotWidth);
        return $clog2(32'sd2 * slotWidth + 32'sd1);
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_ws_edge_detect.sv
// Word-select edge detector: registers ws_i and flags falling (left) and rising (right) edges.
module ws_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ws_i,
    output logic ws_fall_s,
    output logic ws_rise_s
);

    logic ws_q_r;

    // Previous word-select level.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ws_q_r <= 1'b0;
        end else begin
            ws_q_r <= ws_i;
        end
    end

    assign ws_fall_s = ws_q_r & ~ws_i;
    assign ws_rise_s = ~ws_q_r & ws_i;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S slave transmitter: sends each mono sample MSB first in both channel slots.
// Build option I2S_TX_UNDERRUN_MUTE_EN sends silence instead of repeating the last sample on underrun.
module i2s_tx_serializer
    import i2s_tx_pkg::*;
#(
    parameter int PKT_WIDTH   = DEF_PKT_WIDTH,
    parameter int SLOT_WIDTH  = DEF_SLOT_WIDTH,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [PKT_WIDTH-1:0] pkt_i,
    input  logic                 pktChanged_i,
    input  logic                 ws_i,
    output logic                 sd_o,
    output logic                 locked_o,
    output logic                 underrun_o,
    output logic                 overrun_o,
    output logic                 frameErr_o
);

    localparam int CNT_W  = cntWidth(SLOT_WIDTH);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 32'sd1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_SLOT_LAST = CNT_W'(SLOT_WIDTH - 32'sd1);
    localparam logic [CNT_W-1:0]  CNT_STUCK     = CNT_W'(32'sd2 * SLOT_WIDTH);
    localparam logic [GOOD_W-1:0] GOOD_ONE      = GOOD_W'(32'd1);
    localparam logic [GOOD_W-1:0] GOOD_MAX      = GOOD_W'(LOCK_FRAMES);

    logic                 ws_fall_s;
    logic                 ws_rise_s;
    logic                 ws_edge_s;
    txState_t             state_r;
    txState_t             next_state_s;
    logic                 left_start_s;
    logic                 right_start_s;
    logic                 stuck_s;
    logic                 checked_edge_s;
    logic                 frame_err_s;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [GOOD_W-1:0]    good_cnt_r;
    logic [GOOD_W-1:0]    good_next_s;
    logic [PKT_WIDTH-1:0] hold_r;
    logic                 valid_r;
    logic [PKT_WIDTH-1:0] frame_r;
    logic [PKT_WIDTH-1:0] shift_r;
    logic [PKT_WIDTH-1:0] left_data_s;

    ws_edge_detect u_ws_edge (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .ws_i      (ws_i),
        .ws_fall_s (ws_fall_s),
        .ws_rise_s (ws_rise_s)
    );

    assign ws_edge_s = ws_fall_s | ws_rise_s;

    // Slot sequencing; a falling edge always resyncs to a left slot.
    always_comb begin
        next_state_s  = state_r;
        left_start_s  = 1'b0;
        right_start_s = 1'b0;
        stuck_s       = 1'b0;
        if (ws_fall_s) begin
            next_state_s = LEFT;
            left_start_s = 1'b1;
        end else if (ws_rise_s && (state_r != UNLOCKED)) begin
            next_state_s  = RIGHT;
            right_start_s = 1'b1;
        end else if (!ws_edge_s && (state_r != UNLOCKED) && (bit_cnt_r == CNT_STUCK)) begin
            next_state_s = UNLOCKED;
            stuck_s      = 1'b1;
        end else begin
            next_state_s = state_r;
        end
    end

    // Half-frame length check and saturating good-slot counter.
    always_comb begin
        checked_edge_s = ws_edge_s && (state_r != UNLOCKED);
        frame_err_s    = stuck_s || (checked_edge_s && (bit_cnt_r != CNT_SLOT_LAST));
        if (frame_err_s) begin
            good_next_s = '0;
        end else if (checked_edge_s && (good_cnt_r != GOOD_MAX)) begin
            good_next_s = good_cnt_r + GOOD_ONE;
        end else begin
            good_next_s = good_cnt_r;
        end
    end

    // Sample chosen for a new frame: same-cycle strobe bypasses the holding register.
    always_comb begin
        if (pktChanged_i) begin
            left_data_s = pkt_i;
        end else if (valid_r) begin
            left_data_s = hold_r;
        end else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            left_data_s = '0;
`else
            left_data_s = frame_r;
`endif
        end
    end

    // State, counters, sample hand-off, serial shifter and status outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= UNLOCKED;
            bit_cnt_r  <= '0;
            good_cnt_r <= '0;
            hold_r     <= '0;
            valid_r    <= 1'b0;
            frame_r    <= '0;
            shift_r    <= '0;
            sd_o       <= 1'b0;
            locked_o   <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
            frameErr_o <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            good_cnt_r <= good_next_s;
            frameErr_o <= frame_err_s;
            locked_o   <= (next_state_s != UNLOCKED) && (good_next_s >= GOOD_MAX);
            underrun_o <= left_start_s && !pktChanged_i && !valid_r;
            overrun_o  <= pktChanged_i && !left_start_s && valid_r;

            if (ws_edge_s) begin
                bit_cnt_r <= '0;
            end else if (bit_cnt_r != CNT_STUCK) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end

            if (left_start_s) begin
                frame_r <= left_data_s;
                valid_r <= 1'b0;
            end else if (pktChanged_i) begin
                hold_r  <= pkt_i;
                valid_r <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end

            if (next_state_s == UNLOCKED) begin
                sd_o    <= 1'b0;
                shift_r <= '0;
            end else if (left_start_s) begin
                sd_o    <= left_data_s[PKT_WIDTH-1];
                shift_r <= {left_data_s[PKT_WIDTH-2:0], 1'b0};
            end else if (right_start_s) begin
                sd_o    <= frame_r[PKT_WIDTH-1];
                shift_r <= {frame_r[PKT_WIDTH-2:0], 1'b0};
            end else begin
                sd_o    <= shift_r[PKT_WIDTH-1];
                shift_r <= {shift_r[PKT_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
